sd_cmd_responder: RTL and testbench

Card-side endpoint of the SD CMD line, the counterpart of the host's bit-banged CMD PIO. Watches the CMD line, deserialises 48-bit command frames clocked by sd_clk, and checks framing and CRC7. Presents each received command to a soft core over an Avalon-MM slave, then serialises a software-supplied 48-bit response with hardware-generated CRC7. Used for loopback testing and card emulation.

---
 rtl/sd_cmd_pkg.sv | 21 ++
 rtl/sd_cmd_responder_if.sv | 12 +
 rtl/sd_crc7.sv | 26 ++
 rtl/sd_cmd_responder.sv | 217 +++++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared constants, register map and FSM state types for the SD CMD-line responder.
package sd_cmd_pkg;
    localparam int         FRAME_BITS = 48;
    localparam int         CRC_BITS   = 40;   // frame bits 47..8 are covered by CRC7
    localparam logic [6:0] CRC7_POLY  = 7'h09;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CMD_ARG = 2'd1;
    localparam logic [1:0] ADDR_CMD_IDX = 2'd2;
    localparam logic [1:0] ADDR_RSP     = 2'd3;

    localparam int ST_CMD_VALID = 0;
    localparam int ST_CRC_ERR   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_IRQ_EN    = 5;

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_NCR, TX_SHIFT, TX_END} tx_state_t;
endpackage

// File: rtl/sd_cmd_responder_if.sv
// Avalon-MM slave bus plus interrupt between the soft core and the CMD responder.
interface sd_cmd_responder_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), seed 0; clear has priority over enable.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc
);
    logic [6:0] crc_reg;
    logic       feedback;

    assign feedback = crc_reg[6] ^ data_in;
    assign crc      = crc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc_reg <= 7'd0;
        else if (clear)
            crc_reg <= 7'd0;
        else if (enable)
            crc_reg <= {crc_reg[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'd0);
    end
endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line endpoint: receives 48-bit commands, answers with software-supplied responses.
// Build option: define SD_CMD_RSP_CRC_CHECK_EN to check the received CRC7 (otherwise crc_err stays 0).
module sd_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int N_CR        = 2,
    parameter int SYNC_STAGES = 2
)
(
    input  logic                clk,
    input  logic                reset,
    sd_cmd_responder_if.slave   bus,
    input  logic                sd_clk,
    inout  wire                 bidir_port
);
    // {sd_clk, cmd} travel together so the strobe and the sampled bit stay aligned
    logic [1:0] sync_reg [SYNC_STAGES];
    logic       sdclk_prev_reg;
    logic       sdclk_s, cmd_s, rise_stb, fall_stb;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    sync_reg[gi] <= 2'b00;
                else if (gi == 0)
                    sync_reg[gi] <= {sd_clk, bidir_port};
                else
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign {sdclk_s, cmd_s} = sync_reg[SYNC_STAGES-1];
    assign rise_stb = sdclk_s & ~sdclk_prev_reg;
    assign fall_stb = ~sdclk_s & sdclk_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sdclk_prev_reg <= 1'b0;
        else       sdclk_prev_reg <= sdclk_s;
    end

    rx_state_t                rx_state_reg;
    tx_state_t                tx_state_reg;
    logic [5:0]               rx_cnt_reg;
    logic [FRAME_BITS-2:0]    rx_shift_reg;
    logic [6:0]               tx_cnt_reg;
    logic [FRAME_BITS-1:0]    tx_shift_reg;
    logic                     line_oe_reg, line_out_reg;
    logic                     cmd_valid_reg, crc_err_reg, frame_err_reg, overrun_reg, irq_en_reg;
    logic [31:0]              cmd_arg_reg, readdata_reg;
    logic [5:0]               cmd_idx_reg, rsp_idx_reg;
    logic [6:0]               rx_crc, tx_crc;

    logic bus_wr, bus_rd, status_clr, tx_busy, tx_start;
    logic frame_ok, crc_ok, rx_crc_en, tx_crc_en;

    assign bus_wr     = bus.chipselect & ~bus.write_n;
    assign bus_rd     = bus.chipselect & bus.write_n;
    assign status_clr = bus_wr & (bus.address == ADDR_STATUS) & bus.writedata[ST_CMD_VALID];
    assign tx_busy    = (tx_state_reg != TX_IDLE);
    assign tx_start   = bus_wr & (bus.address == ADDR_RSP) & ~tx_busy;

    assign frame_ok = rx_shift_reg[FRAME_BITS-2] & rx_shift_reg[0];
`ifdef SD_CMD_RSP_CRC_CHECK_EN
    assign crc_ok = (rx_shift_reg[7:1] == rx_crc);
`else
    logic unused_rx_crc;
    assign unused_rx_crc = ^{rx_crc, rx_shift_reg[7:1]};
    assign crc_ok = 1'b1;
`endif

    // The leading 0 start bit leaves a zero-seeded CRC unchanged, so RX feeds from bit 46 on
    assign rx_crc_en = rise_stb & (rx_state_reg == RX_SHIFT) & (rx_cnt_reg < 6'(CRC_BITS));
    assign tx_crc_en = fall_stb &
                       (((tx_state_reg == TX_NCR) & (tx_cnt_reg == 7'(N_CR))) |
                        ((tx_state_reg == TX_SHIFT) & (tx_cnt_reg < 7'(CRC_BITS - 1))));

    sd_crc7 u_rx_crc (.clk(clk), .reset(reset), .clear(rx_state_reg == RX_IDLE),
                      .enable(rx_crc_en), .data_in(cmd_s), .crc(rx_crc));
    sd_crc7 u_tx_crc (.clk(clk), .reset(reset), .clear(tx_start),
                      .enable(tx_crc_en), .data_in(tx_shift_reg[FRAME_BITS-1]), .crc(tx_crc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= 6'd0;
            rx_shift_reg  <= '0;
            cmd_valid_reg <= 1'b0;
            crc_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            cmd_arg_reg   <= 32'd0;
            cmd_idx_reg   <= 6'd0;
        end else begin
            if (status_clr) begin
                cmd_valid_reg <= 1'b0;
                crc_err_reg   <= 1'b0;
                frame_err_reg <= 1'b0;
                overrun_reg   <= 1'b0;
            end
            if (tx_busy) begin
                rx_state_reg <= RX_IDLE;
            end else begin
                case (rx_state_reg)
                    RX_IDLE: if (rise_stb && !cmd_s) begin
                        rx_state_reg <= RX_SHIFT;
                        rx_cnt_reg   <= 6'd1;
                    end
                    RX_SHIFT: if (rise_stb) begin
                        rx_shift_reg <= {rx_shift_reg[FRAME_BITS-3:0], cmd_s};
                        rx_cnt_reg   <= rx_cnt_reg + 6'd1;
                        if (rx_cnt_reg == 6'(FRAME_BITS - 1))
                            rx_state_reg <= RX_CHECK;
                    end
                    RX_CHECK: begin
                        rx_state_reg <= RX_IDLE;
                        if (!frame_ok) frame_err_reg <= 1'b1;
                        if (!crc_ok)   crc_err_reg   <= 1'b1;
                        // A clear landing in this same cycle frees the slot for the new command
                        if (frame_ok && crc_ok) begin
                            if (cmd_valid_reg && !status_clr) begin
                                overrun_reg <= 1'b1;
                            end else begin
                                cmd_valid_reg <= 1'b1;
                                cmd_idx_reg   <= rx_shift_reg[45:40];
                                cmd_arg_reg   <= rx_shift_reg[39:8];
                            end
                        end
                    end
                    default: rx_state_reg <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= 7'd0;
            tx_shift_reg <= '0;
            line_oe_reg  <= 1'b0;
            line_out_reg <= 1'b0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: if (tx_start) begin
                    tx_state_reg <= TX_NCR;
                    tx_cnt_reg   <= 7'd0;
                    tx_shift_reg <= {2'b00, rsp_idx_reg, bus.writedata, 7'd0, 1'b1};
                    line_oe_reg  <= 1'b1;
                    line_out_reg <= 1'b1;
                end
                TX_NCR: if (fall_stb) begin
                    if (tx_cnt_reg == 7'(N_CR)) begin
                        line_out_reg <= tx_shift_reg[FRAME_BITS-1];
                        tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                        tx_cnt_reg   <= 7'd0;
                        tx_state_reg <= TX_SHIFT;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 7'd1;
                    end
                end
                TX_SHIFT: if (fall_stb) begin
                    tx_cnt_reg <= tx_cnt_reg + 7'd1;
                    // tx_cnt_reg is the index of the bit currently on the line
                    if (tx_cnt_reg == 7'(CRC_BITS - 1)) begin
                        line_out_reg <= tx_crc[6];
                        tx_shift_reg <= {tx_crc[5:0], 1'b1, 41'd0};
                    end else begin
                        line_out_reg <= tx_shift_reg[FRAME_BITS-1];
                        tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                        if (tx_cnt_reg == 7'(FRAME_BITS - 2))
                            tx_state_reg <= TX_END;
                    end
                end
                TX_END: if (fall_stb) begin
                    line_oe_reg  <= 1'b0;
                    line_out_reg <= 1'b0;
                    tx_state_reg <= TX_IDLE;
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_reg   <= 1'b0;
            rsp_idx_reg  <= 6'd0;
            readdata_reg <= 32'd0;
        end else begin
            if (bus_wr && bus.address == ADDR_STATUS)  irq_en_reg  <= bus.writedata[ST_IRQ_EN];
            if (bus_wr && bus.address == ADDR_CMD_IDX) rsp_idx_reg <= bus.writedata[5:0];
            if (bus_rd) begin
                readdata_reg <= 32'd0;
                case (bus.address)
                    ADDR_STATUS: begin
                        readdata_reg[ST_CMD_VALID] <= cmd_valid_reg;
                        readdata_reg[ST_CRC_ERR]   <= crc_err_reg;
                        readdata_reg[ST_FRAME_ERR] <= frame_err_reg;
                        readdata_reg[ST_OVERRUN]   <= overrun_reg;
                        readdata_reg[ST_TX_BUSY]   <= tx_busy;
                        readdata_reg[ST_IRQ_EN]    <= irq_en_reg;
                    end
                    ADDR_CMD_ARG: readdata_reg <= cmd_arg_reg;
                    ADDR_CMD_IDX: readdata_reg <= {26'd0, cmd_idx_reg};
                    default:      readdata_reg <= 32'd0;
                endcase
            end
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = cmd_valid_reg & irq_en_reg;
    assign bidir_port   = line_oe_reg ? line_out_reg : 1'bz;
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Randomised bench for sd_cmd_responder against a frame-level model of the CMD protocol.
module tb_sd_cmd_responder;
    localparam int N_CR = 2;

    logic clk = 1'b0, reset = 1'b1, sd_clk = 1'b0;
    logic host_oe = 1'b1, host_bit = 1'b1;
    wire  cmd_line;
    assign cmd_line = host_oe ? host_bit : 1'bz;

    sd_cmd_responder_if bus ();
    sd_cmd_responder #(.N_CR(N_CR), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus), .sd_clk(sd_clk), .bidir_port(cmd_line));

    always #5 clk = ~clk;

    int n_cmp = 0, n_mis = 0;
    bit m_valid, m_crc_err, m_frame_err, m_overrun, m_irq_en;
    logic [31:0] m_arg;
    logic [5:0]  m_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            logic fb = c[6] ^ d[i];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [7:0] head, input logic [31:0] arg);
        return {head, arg, crc7_calc({head, arg}), 1'b1};
    endfunction

    task automatic model_reset();
        {m_valid, m_crc_err, m_frame_err, m_overrun, m_irq_en} = '0;
        m_arg = '0;
        m_idx = '0;
    endtask

    task automatic model_status_write(input logic [31:0] d);
        if (d[0]) {m_valid, m_crc_err, m_frame_err, m_overrun} = '0;
        m_irq_en = d[5];
    endtask

    task automatic model_frame(input logic [47:0] f);
        bit fr_ok, crc_ok;
        fr_ok = f[46] & f[0];
`ifdef SD_CMD_RSP_CRC_CHECK_EN
        crc_ok = (crc7_calc(f[47:8]) == f[7:1]);
`else
        crc_ok = 1'b1;
`endif
        if (!fr_ok)  m_frame_err = 1'b1;
        if (!crc_ok) m_crc_err = 1'b1;
        if (fr_ok && crc_ok) begin
            if (m_valid) m_overrun = 1'b1;
            else begin
                m_valid = 1'b1;
                m_arg = f[39:8];
                m_idx = f[45:40];
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    task automatic check_regs(input string tag, input bit busy);
        logic [31:0] st, arg, idx;
        bus_read(2'd0, st);
        bus_read(2'd1, arg);
        bus_read(2'd2, idx);
        check({tag, "_status"}, st, {26'd0, m_irq_en, busy, m_overrun, m_frame_err, m_crc_err, m_valid});
        check({tag, "_arg"}, arg, m_arg);
        check({tag, "_idx"}, idx, {26'd0, m_idx});
        check({tag, "_irq"}, bus.irq, m_valid & m_irq_en);
        $display("%s: status %h arg %h idx %0d irq %b", tag, st, arg, idx[5:0], bus.irq);
    endtask

    // One sd_clk period from the host side; clr_hit lands a status clear on the RX check cycle
    task automatic host_bit_cycle(input logic b, input bit clr_hit);
        host_bit = b;
        repeat (4) @(negedge clk);
        sd_clk = 1'b1;
        if (clr_hit) begin
            repeat (3) @(negedge clk);
            bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd0; bus.writedata = 32'h21;
            @(negedge clk);
            bus.chipselect = 1'b0; bus.write_n = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        sd_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f, input bit clr_hit);
        host_oe = 1'b1;
        for (int i = 47; i >= 0; i--) host_bit_cycle(f[i], clr_hit && (i == 0));
        host_bit_cycle(1'b1, 1'b0);
        host_bit_cycle(1'b1, 1'b0);
    endtask

    task automatic run_response(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                                input logic [47:0] exp, input bit extra_wr, input bit rst_mid);
        logic [47:0] cap = '0;
        logic [31:0] st;
        int high_cnt = 0, oe_cnt = 0, k_rst;
        logic last_oe = 1'b1;
        host_oe = 1'b0;
        bus_write(2'd2, {26'd0, idx});
        bus_write(2'd3, arg);
        bus_read(2'd0, st);
        check({tag, "_busy"}, st[4], 1'b1);
        if (extra_wr) bus_write(2'd3, ~arg);
        k_rst = N_CR + 1 + 20;
        for (int k = 1; k <= N_CR + 49; k++) begin
            sd_clk = 1'b1;
            repeat (8) @(negedge clk);
            sd_clk = 1'b0;
            repeat (8) @(negedge clk);
            if (rst_mid && k == k_rst) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                check({tag, "_rst_oe"}, dut.line_oe_reg, 1'b0);
                check({tag, "_rst_irq"}, bus.irq, 1'b0);
                check({tag, "_rst_rdata"}, bus.readdata, 32'd0);
                repeat (3) @(negedge clk);
                host_oe = 1'b1;
                host_bit = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                model_reset();
                $display("%s: reset during response bit 20", tag);
                return;
            end
            last_oe = dut.line_oe_reg;
            if (last_oe) oe_cnt++;
            if (k <= N_CR && last_oe && cmd_line === 1'b1) high_cnt++;
            if (k > N_CR && k <= N_CR + 48) cap = {cap[46:0], cmd_line};
        end
        check({tag, "_ncr_high"}, high_cnt, N_CR);
        check({tag, "_frame"}, cap, exp);
        check({tag, "_drive_len"}, oe_cnt, N_CR + 48);
        check({tag, "_release"}, last_oe, 1'b0);
        host_oe = 1'b1;
        host_bit = 1'b1;
        repeat (4) @(negedge clk);
        $display("%s: response %h captured %h", tag, exp, cap);
        check_regs({tag, "_after"}, 1'b0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        logic [31:0] a;
        logic [5:0]  ix;
        logic [31:0] w;
        int kind;

        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
        model_reset();
        repeat (4) @(negedge clk);
        check("reset_oe", dut.line_oe_reg, 1'b0);
        check("reset_rdata", bus.readdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_regs("reset", 1'b0);

        bus_write(2'd0, 32'h20); model_status_write(32'h20);
        f = 48'h40_0000_0000_95;
        send_frame(f, 1'b0); model_frame(f);
        check_regs("cmd0", 1'b0);

        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        f = 48'h48_0000_01AA_87;
        send_frame(f, 1'b0); model_frame(f);
        check_regs("cmd8", 1'b0);
        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        run_response("rsp8", 6'd8, 32'h0000_01AA, 48'h08_0000_01AA_13, 1'b0, 1'b0);

        f = 48'h48_0000_01AA_87;
        f[7:1] = f[7:1] ^ 7'h01;
        send_frame(f, 1'b0); model_frame(f);
        check_regs("cmd8_badcrc", 1'b0);

        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        f = make_frame(8'h51, 32'h1234_5678);
        send_frame(f, 1'b0); model_frame(f);
        f = make_frame(8'h52, 32'hCAFE_0001);
        send_frame(f, 1'b0); model_frame(f);
        check_regs("overrun", 1'b0);

        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        f = make_frame(8'h00, 32'h0BAD_F00D);
        send_frame(f, 1'b0); model_frame(f);
        check_regs("txbit0", 1'b0);

        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        f = make_frame(8'h41, 32'h1111_2222);
        send_frame(f, 1'b0); model_frame(f);
        f = make_frame(8'h42, 32'h3333_4444);
        send_frame(f, 1'b1); model_status_write(32'h21); model_frame(f);
        check_regs("clr_race", 1'b0);

        bus_write(2'd0, 32'h21); model_status_write(32'h21);
        run_response("rsp_rst", 6'd3, 32'hA5A5_5A5A, 48'd0, 1'b0, 1'b1);
        check_regs("post_rst", 1'b0);
        f = make_frame(8'h77, 32'hDEAD_BEEF);
        send_frame(f, 1'b0); model_frame(f);
        check_regs("post_rst_cmd", 1'b0);

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = 32'd0;
                w[0] = 1'($urandom_range(0, 1));
                w[5] = 1'($urandom_range(0, 1));
                bus_write(2'd0, w); model_status_write(w);
            end
            ix = 6'($urandom);
            a = $urandom;
            kind = $urandom_range(0, 3);
            f = make_frame({2'b01, ix}, a);
            if (kind == 1) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            if (kind == 2) f = make_frame({2'b00, ix}, a);
            if (kind == 3) f[0] = 1'b0;
            send_frame(f, 1'b0); model_frame(f);
            check_regs($sformatf("rand%0d_k%0d", t, kind), 1'b0);
            if (t % 4 == 3) begin
                ix = 6'($urandom);
                a = $urandom;
                run_response($sformatf("rand_rsp%0d", t), ix, a,
                             make_frame({2'b00, ix}, a), 1'b1, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
